// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready select handshake.
// Three output modes: LATCH holds the decoded line, PULSE drives it for one
// cycle, SCAN rotates the hot line through every output with a fixed dwell.
// Intended for driving enable lines of peripheral banks or LED groups.

module decoder_onehot_seq #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel,
  output logic                    sel_ready,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int OUT_W = 1 << SEL_W;

  localparam logic [1:0] MODE_LATCH = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PULSE = 2'd2,
    ST_SCAN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   pos_q, pos_d;

  logic               accept;
  logic [SEL_W-1:0]   idx_next;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  // A scan owns the output until it finishes, so codes are refused while it runs.
  assign sel_ready = en & (state_q != ST_SCAN);
  assign accept    = sel_valid & sel_ready;
  assign idx_next  = idx_q + SEL_W'(1);

  // Next-state and next-output decision for the decoder FSM.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pos_d   = pos_q;

    if (!en) begin
      state_d = ST_IDLE;
      y_d     = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      pos_d   = '0;
    end else if (state_q == ST_SCAN) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (&pos_q) begin
        // Every output has had its dwell: clear and flag completion.
        state_d = ST_IDLE;
        y_d     = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        pos_d   = '0;
      end else begin
        idx_d = idx_next;
        pos_d = pos_q + SEL_W'(1);
        y_d   = onehot(idx_next);
        cnt_d = DWELL_RELOAD;
      end
    end else if (accept) begin
      case (mode)
        MODE_LATCH: begin
          state_d = ST_HOLD;
          y_d     = onehot(sel);
        end
        MODE_PULSE: begin
          state_d = ST_PULSE;
          y_d     = onehot(sel);
        end
        MODE_SCAN: begin
          state_d = ST_SCAN;
          y_d     = onehot(sel);
          busy_d  = 1'b1;
          cnt_d   = DWELL_RELOAD;
          idx_d   = sel;
          pos_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          y_d     = '0;
        end
      endcase
    end else if (state_q == ST_PULSE) begin
      state_d = ST_IDLE;
      y_d     = '0;
    end

    y_valid_d = |y_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Bench for decoder_onehot_seq: a 2-bit/DWELL=2 instance tracked every cycle
// against a queue-based behavioural model, plus a 3-bit/DWELL=3 instance
// exercised with directed checks.

module tb_decoder_onehot_seq;

  localparam int DWELL_A = 2;
  localparam int OUT_A   = 4;

  logic       clk;
  logic       rst_n;
  logic       en;

  logic [1:0] a_mode;
  logic       a_valid;
  logic [1:0] a_sel;
  logic       a_ready;
  logic [3:0] a_y;
  logic       a_yv;
  logic       a_busy;
  logic       a_done;

  logic [1:0] b_mode;
  logic       b_valid;
  logic [2:0] b_sel;
  logic       b_ready;
  logic [7:0] b_y;
  logic       b_yv;
  logic       b_busy;
  logic       b_done;

  int testsRun  = 0;
  int failCount = 0;
  logic checkEnable = 1'b0;

  decoder_onehot_seq #(.SEL_W(2), .DWELL(DWELL_A), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(a_mode),
    .sel_valid(a_valid), .sel(a_sel), .sel_ready(a_ready),
    .y(a_y), .y_valid(a_yv), .busy(a_busy), .done(a_done)
  );

  decoder_onehot_seq #(.SEL_W(3), .DWELL(3), .CNT_W(8)) dutB (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(b_mode),
    .sel_valid(b_valid), .sel(b_sel), .sel_ready(b_ready),
    .y(b_y), .y_valid(b_yv), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of instance A: a scan is a queue of upcoming output words.
  logic [3:0] expY;
  logic       expBusy;
  logic       expDone;
  logic       expPulse;
  logic       modelAccept;
  logic [3:0] scanQ[$];

  initial begin
    expY = '0; expBusy = 1'b0; expDone = 1'b0; expPulse = 1'b0;
  end

  always @(posedge clk) begin
    modelAccept = a_valid && en && (scanQ.size() == 0);
    expDone = 1'b0;
    if (!rst_n || !en) begin
      expY = '0;
      expPulse = 1'b0;
      scanQ.delete();
    end else if (scanQ.size() != 0) begin
      expY = scanQ.pop_front();
      if (scanQ.size() == 0) expDone = 1'b1;
    end else if (modelAccept) begin
      expPulse = 1'b0;
      case (a_mode)
        2'd0: expY = 4'(1 << a_sel);
        2'd1: begin expY = 4'(1 << a_sel); expPulse = 1'b1; end
        2'd2: begin
          expY = 4'(1 << a_sel);
          for (int k = 1; k < OUT_A * DWELL_A; k++)
            scanQ.push_back(4'(1 << ((int'(a_sel) + k / DWELL_A) % OUT_A)));
          scanQ.push_back(4'b0000);
        end
        default: expY = '0;
      endcase
    end else if (expPulse) begin
      expY = '0;
      expPulse = 1'b0;
    end
    expBusy = (scanQ.size() != 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, shortly after the edge, instance A must agree with the model.
  always @(posedge clk) begin
    #1;
    if (checkEnable) begin
      checkOutput("model_y",         32'(a_y),     32'(expY));
      checkOutput("model_y_valid",   32'(a_yv),    32'(|expY));
      checkOutput("model_busy",      32'(a_busy),  32'(expBusy));
      checkOutput("model_done",      32'(a_done),  32'(expDone));
      checkOutput("model_sel_ready", 32'(a_ready), 32'(en && (scanQ.size() == 0)));
    end
  end

  task automatic applyStimulus(input logic rstN, input logic enV, input logic [1:0] m,
                               input logic v, input logic [1:0] s);
    @(negedge clk);
    rst_n = rstN; en = enV; a_mode = m; a_valid = v; a_sel = s;
    b_valid = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [1:0] m, input logic v, input logic [2:0] s);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; b_mode = m; b_valid = v; b_sel = s;
    a_valid = 1'b0;
  endtask

  logic [3:0] scanExp [8] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000,
                              4'b0001, 4'b0001, 4'b0010, 4'b0010};

  initial begin
    rst_n = 1'b0; en = 1'b1;
    a_mode = 2'd0; a_valid = 1'b0; a_sel = 2'd0;
    b_mode = 2'd0; b_valid = 1'b0; b_sel = 3'd0;

    // Reset for three cycles, then release.
    repeat (3) applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    checkEnable = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("reset_y",     32'(a_y),     32'h0);
    checkOutput("reset_busy",  32'(a_busy),  32'h0);
    checkOutput("reset_done",  32'(a_done),  32'h0);
    checkOutput("reset_ready", 32'(a_ready), 32'h1);

    // LATCH sel=2, hold for ten cycles, then sel=0.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 2'd2);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("latch_sel2", 32'(a_y), 32'h4);
    repeat (10) applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("latch_hold", 32'(a_y), 32'h4);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("latch_sel0", 32'(a_y), 32'h1);

    // PULSE back-to-back: sel=3 then sel=1.
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 2'd3);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 2'd1);
    checkOutput("pulse_first", 32'(a_y), 32'h8);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
    checkOutput("pulse_second", 32'(a_y), 32'h2);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 2'd0);
    checkOutput("pulse_clear", 32'(a_y), 32'h0);

    // SCAN from sel=2 with wrap; sel_valid held high throughout must be ignored.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b1, 2'd2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 2'd1);
      checkOutput("scan_y",    32'(a_y),    32'(scanExp[i]));
      checkOutput("scan_busy", 32'(a_busy), 32'h1);
    end
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("scan_end_y",    32'(a_y),    32'h0);
    checkOutput("scan_end_done", 32'(a_done), 32'h1);
    checkOutput("scan_end_busy", 32'(a_busy), 32'h0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("scan_done_once", 32'(a_done), 32'h0);
    checkOutput("scan_no_accept", 32'(a_y),    32'h0);

    // Abort a scan by dropping en.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b1, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("abort_en_y",    32'(a_y),    32'h0);
    checkOutput("abort_en_busy", 32'(a_busy), 32'h0);
    checkOutput("abort_en_done", 32'(a_done), 32'h0);
    repeat (8) applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);

    // Abort a scan by reset.
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b1, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("abort_rst_y",    32'(a_y),    32'h0);
    checkOutput("abort_rst_busy", 32'(a_busy), 32'h0);
    checkOutput("abort_rst_done", 32'(a_done), 32'h0);
    repeat (8) applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);

    // Mode 11 clears a latched output and leaves the block ready.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 2'd1);
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 2'd2);
    checkOutput("mode11_pre", 32'(a_y), 32'h2);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    checkOutput("mode11_y",     32'(a_y),     32'h0);
    checkOutput("mode11_ready", 32'(a_ready), 32'h1);

    // Wider instance: LATCH every code.
    for (int s = 0; s < 8; s++) begin
      applyStimulusB(2'd0, 1'b1, 3'(s));
      applyStimulusB(2'd0, 1'b0, 3'd0);
      checkOutput("b_latch", 32'(b_y), 32'(1 << s));
    end
    applyStimulusB(2'd3, 1'b1, 3'd2);
    applyStimulusB(2'd0, 1'b0, 3'd0);
    checkOutput("b_mode11_y",     32'(b_y),     32'h0);
    checkOutput("b_mode11_yv",    32'(b_yv),    32'h0);
    checkOutput("b_mode11_ready", 32'(b_ready), 32'h1);

    // Wider instance: SCAN from the top code wraps to 0 after three cycles.
    applyStimulusB(2'd2, 1'b1, 3'd7);
    for (int i = 0; i < 24; i++) begin
      applyStimulusB(2'd0, 1'b0, 3'd0);
      checkOutput("b_scan_y",    32'(b_y),    32'(1 << ((7 + i / 3) % 8)));
      checkOutput("b_scan_busy", 32'(b_busy), 32'h1);
    end
    applyStimulusB(2'd0, 1'b0, 3'd0);
    checkOutput("b_scan_end_y",    32'(b_y),    32'h0);
    checkOutput("b_scan_end_done", 32'(b_done), 32'h1);

    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
